// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared constants for the memory/I/O responder
package mem_io_responder_pkg;
  localparam int          BYTE_W       = 8;
  localparam int          IO_SEL_BIT   = 17;
  localparam logic [31:0] IO_DATA_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_STAT_ADDR = 32'h0003_0004;

  typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// rtl/mem_io_responder_byte_fifo.sv - byte FIFO with wrapping pointers and occupancy count
module mem_io_responder_byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  byte_t                    din,
  input  logic                     pop,
  output byte_t                    dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  byte_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte RAM plus console I/O window behind the byte-serial RAM bus
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_addr_i,
  input  logic [7:0]  ram_din_i,
  input  logic        ram_wr_i,
  output logic [7:0]  ram_dout_o,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready,
  input  logic        io_rx_valid,
  input  logic [7:0]  io_rx_data,
  output logic        io_rx_ready,
  output logic        io_tx_full,
  output logic        tx_overflow,
  output logic        program_finish
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  byte_t       mem [2**ADDR_WIDTH];
  logic [31:0] prev_addr;
  logic        prev_wr;
  logic        first_q;
  logic        new_access;
  logic        io_sel, is_data, is_stat;
  logic        tx_push, tx_pop, tx_empty;
  logic        rx_push, rx_pop, rx_empty, rx_full;
  byte_t       rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic        unused_count;

  // I/O side effects fire once per access even if the controller holds the bus.
  assign new_access = first_q || (ram_addr_i != prev_addr) || (ram_wr_i != prev_wr);
  assign io_sel     = ram_addr_i[IO_SEL_BIT];
  assign is_data    = io_sel && (ram_addr_i == IO_DATA_ADDR);
  assign is_stat    = io_sel && (ram_addr_i == IO_STAT_ADDR);

  assign tx_pop      = io_tx_valid && io_tx_ready;
  assign tx_push     = ram_wr_i && is_data && new_access;
  assign io_tx_valid = !tx_empty;
  assign rx_push     = io_rx_valid && io_rx_ready;
  assign rx_pop      = !ram_wr_i && is_data && new_access && !rx_empty;
  assign io_rx_ready = !rx_full;
  assign unused_count = ^{tx_count, rx_count};

  mem_io_responder_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(ram_din_i), .pop(tx_pop),
    .dout(io_tx_data), .empty(tx_empty), .full(io_tx_full), .count(tx_count)
  );

  mem_io_responder_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(io_rx_data), .pop(rx_pop),
    .dout(rx_head), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  always_ff @(posedge clk) begin
    if (!io_sel && ram_wr_i) mem[ram_addr_i[ADDR_WIDTH-1:0]] <= ram_din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_dout_o     <= '0;
      prev_addr      <= '0;
      prev_wr        <= 1'b0;
      first_q        <= 1'b1;
      tx_overflow    <= 1'b0;
      program_finish <= 1'b0;
    end else begin
      prev_addr <= ram_addr_i;
      prev_wr   <= ram_wr_i;
      first_q   <= 1'b0;
      if (!ram_wr_i) begin
        if (!io_sel)     ram_dout_o <= mem[ram_addr_i[ADDR_WIDTH-1:0]];
        else if (is_data) begin
          if (new_access) ram_dout_o <= rx_empty ? 8'h00 : rx_head;
        end
        else if (is_stat) ram_dout_o <= {6'b0, !rx_empty, io_tx_full};
        else              ram_dout_o <= 8'h00;
      end
      if (tx_push && io_tx_full && !tx_pop) tx_overflow <= 1'b1;
      if (ram_wr_i && is_stat && new_access) program_finish <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed plus randomized bench against a queue-based reference model
module tb_mem_io_responder;
  localparam logic [31:0] DATA = 32'h30000;
  localparam logic [31:0] STAT = 32'h30004;
  localparam int          DEPTH = 8;

  logic        clk = 0;
  logic        rst;
  logic [31:0] ram_addr_i;
  logic [7:0]  ram_din_i;
  logic        ram_wr_i;
  logic [7:0]  ram_dout_o;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready;
  logic        io_rx_valid;
  logic [7:0]  io_rx_data;
  logic        io_rx_ready;
  logic        io_tx_full;
  logic        tx_overflow;
  logic        program_finish;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram_m [int];
  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  logic [7:0]  exp_dout;
  logic        ovf_m, fin_m, first_m, pwr_m;
  logic [31:0] paddr_m;
  logic [7:0]  saved;

  always #5 clk = ~clk;

  mem_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ram_addr_i(ram_addr_i), .ram_din_i(ram_din_i),
    .ram_wr_i(ram_wr_i), .ram_dout_o(ram_dout_o), .io_tx_valid(io_tx_valid),
    .io_tx_data(io_tx_data), .io_tx_ready(io_tx_ready), .io_rx_valid(io_rx_valid),
    .io_rx_data(io_rx_data), .io_rx_ready(io_rx_ready), .io_tx_full(io_tx_full),
    .tx_overflow(tx_overflow), .program_finish(program_finish)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":dout"}, ram_dout_o, exp_dout);
    chk({tag, ":tx_valid"}, {7'b0, io_tx_valid}, {7'b0, txq.size() > 0});
    if (txq.size() > 0) chk({tag, ":tx_data"}, io_tx_data, txq[0]);
    chk({tag, ":tx_full"}, {7'b0, io_tx_full}, {7'b0, txq.size() == DEPTH});
    chk({tag, ":rx_ready"}, {7'b0, io_rx_ready}, {7'b0, rxq.size() < DEPTH});
    chk({tag, ":overflow"}, {7'b0, tx_overflow}, {7'b0, ovf_m});
    chk({tag, ":finish"}, {7'b0, program_finish}, {7'b0, fin_m});
  endtask

  task automatic do_reset(input string tag);
    rst = 1; ram_addr_i = 0; ram_din_i = 0; ram_wr_i = 0;
    io_tx_ready = 0; io_rx_valid = 0; io_rx_data = 0;
    @(posedge clk); #1;
    txq.delete(); rxq.delete();
    exp_dout = 0; ovf_m = 0; fin_m = 0; first_m = 1; pwr_m = 0; paddr_m = 0;
    check_all(tag);
    rst = 0;
  endtask

  // One bus cycle: drive, advance the model by the bus rules, clock, compare.
  task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic w,
                     input logic txr, input logic rxv, input logic [7:0] rxd, input string tag);
    bit nw, txpop;
    int rx_n0;
    ram_addr_i = a; ram_din_i = d; ram_wr_i = w;
    io_tx_ready = txr; io_rx_valid = rxv; io_rx_data = rxd;
    nw    = first_m || (a != paddr_m) || (w != pwr_m);
    txpop = txr && (txq.size() > 0);
    rx_n0 = rxq.size();
    if (!w) begin
      if (!a[17])        exp_dout = ram_m[int'(a[16:0])];
      else if (a == DATA) begin
        if (nw) exp_dout = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
      end
      else if (a == STAT) exp_dout = {6'b0, rxq.size() > 0, txq.size() == DEPTH};
      else                exp_dout = 8'h00;
    end
    if (txpop) void'(txq.pop_front());
    if (w) begin
      if (!a[17]) ram_m[int'(a[16:0])] = d;
      else if (a == DATA && nw) begin
        if (txq.size() < DEPTH) txq.push_back(d);
        else ovf_m = 1;
      end
      else if (a == STAT && nw) fin_m = 1;
    end
    if (rxv && rx_n0 < DEPTH) rxq.push_back(rxd);
    paddr_m = a; pwr_m = w; first_m = 0;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    do_reset("reset0");

    // RAM: write then read back with one-cycle latency
    cyc(32'h10, 8'hA5, 1, 0, 0, 0, "ram_wr");
    for (int i = 0; i < 20; i++)
      if (i != 16) cyc(i, 8'($urandom), 1, 0, 0, 0, "ram_fill");
    for (int i = 16; i < 20; i++) cyc(i, 0, 0, 0, 0, 0, "ram_rd");
    cyc(32'h10, 0, 0, 0, 0, 0, "ram_rd_a5");
    chk("ram_a5", ram_dout_o, 8'hA5);

    // TX: two bytes queued, then drained
    cyc(DATA, 8'h41, 1, 0, 0, 0, "tx_w41");
    cyc(0, 0, 0, 0, 0, 0, "idle");
    cyc(DATA, 8'h42, 1, 0, 0, 0, "tx_w42");
    chk("tx_head41", io_tx_data, 8'h41);
    cyc(0, 0, 0, 1, 0, 0, "tx_drain1");
    cyc(0, 0, 0, 1, 0, 0, "tx_drain2");
    chk("tx_empty", {7'b0, io_tx_valid}, 8'h00);

    // TX overflow: nine distinct writes
    for (int i = 0; i < 9; i++) begin
      cyc(DATA, 8'($urandom), 1, 0, 0, 0, "tx_fill");
      cyc(STAT, 0, 0, 0, 0, 0, "stat_rd");
    end
    chk("stat_full", ram_dout_o, 8'h01);
    chk("overflow_set", {7'b0, tx_overflow}, 8'h01);

    // halt flag is sticky
    cyc(STAT, 8'h00, 1, 0, 0, 0, "stat_wr");
    cyc(STAT, 8'h00, 1, 0, 0, 0, "stat_wr_hold");
    cyc(0, 0, 0, 0, 0, 0, "idle");
    chk("finish_sticky", {7'b0, program_finish}, 8'h01);

    // RX: held read pops once
    cyc(0, 0, 0, 0, 1, 8'h11, "rx_push11");
    cyc(0, 0, 0, 0, 1, 8'h22, "rx_push22");
    cyc(DATA, 0, 0, 0, 0, 0, "rx_rd1");
    chk("rx_11", ram_dout_o, 8'h11);
    cyc(DATA, 0, 0, 0, 0, 0, "rx_hold");
    cyc(DATA, 0, 0, 0, 0, 0, "rx_hold");
    chk("rx_hold11", ram_dout_o, 8'h11);
    cyc(0, 0, 0, 0, 0, 0, "idle");
    cyc(DATA, 0, 0, 0, 0, 0, "rx_rd2");
    chk("rx_22", ram_dout_o, 8'h22);
    cyc(0, 0, 0, 0, 0, 0, "idle");
    cyc(DATA, 0, 0, 0, 0, 0, "rx_rd3");
    chk("rx_empty0", ram_dout_o, 8'h00);

    // randomized traffic
    begin
      logic [31:0] a;
      logic        w;
      a = 0; w = 0;
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 5))
            0, 1:    a = DATA;
            2:       a = STAT;
            3:       a = 32'h30008;
            default: a = 32'($urandom_range(0, 19));
          endcase
          w = ($urandom_range(0, 2) == 0);
        end
        cyc(a, 8'($urandom), w, 1'($urandom), 1'($urandom), 8'($urandom), "rand");
      end
    end

    // reset in the middle of a TX burst
    do_reset("reset1");
    for (int i = 0; i < 3; i++) begin
      cyc(DATA, 8'($urandom), 1, 0, 0, 0, "burst");
      cyc(0, 0, 0, 0, 0, 0, "idle");
    end
    saved = 8'($urandom);
    cyc(32'h20, saved, 1, 0, 0, 0, "ram_wr20");
    cyc(DATA, 8'h77, 1, 0, 0, 0, "burst4");
    do_reset("reset_mid");
    chk("rst_rx_ready", {7'b0, io_rx_ready}, 8'h01);
    cyc(32'h20, 0, 0, 0, 0, 0, "ram_rd20");
    chk("ram_kept", ram_dout_o, saved);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
